// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-cache field widths, FSM state encoding
// and a helper that extracts one 32-bit word from a cache block.
package cpu_pkg;

  localparam int OFFSET_BITS   = 2;
  localparam int INDEX_BITS    = 3;
  localparam int TAG_BITS      = 3;
  localparam int NUM_BLOCKS    = 8;
  localparam int BLOCK_BITS    = 128;
  localparam int WORD_BITS     = 32;
  localparam int MEM_ADDR_BITS = 6;

  typedef enum logic [1:0] {
    IC_IDLE     = 2'd0,
    IC_MEM_READ = 2'd1,
    IC_UPDATE   = 2'd2
  } ic_state_t;

  // Word 0 lives in bits [31:0] of the block.
  function automatic logic [WORD_BITS-1:0] select_word(
    input logic [BLOCK_BITS-1:0]  blk,
    input logic [OFFSET_BITS-1:0] offset
  );
    return blk[{offset, 5'd0} +: WORD_BITS];
  endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Block-read bus between the instruction cache and instruction memory.
interface icache_direct_mapped_if;
  import cpu_pkg::*;

  logic [MEM_ADDR_BITS-1:0] MEM_ADDRESS;
  logic                     MEM_READ;
  logic [BLOCK_BITS-1:0]    MEM_READDATA;
  logic                     MEM_BUSYWAIT;

  modport master (
    output MEM_ADDRESS,
    output MEM_READ,
    input  MEM_READDATA,
    input  MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_ADDRESS,
    input  MEM_READ,
    output MEM_READDATA,
    output MEM_BUSYWAIT
  );

endinterface

// File: rtl/icache_ctrl_fsm.sv
// Miss-handling controller: IDLE -> MEM_READ -> UPDATE. Latches the missing
// block address when leaving IDLE so a (protocol-violating) PC change during
// the miss cannot redirect the fill.
module icache_ctrl_fsm
  import cpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hit,
  input  logic [TAG_BITS-1:0]      req_tag,
  input  logic [INDEX_BITS-1:0]    req_index,
  input  logic                     mem_busywait,
  output logic                     mem_read,
  output logic [MEM_ADDR_BITS-1:0] mem_address,
  output logic                     busywait,
  output logic                     capture,
  output logic                     line_write
);

  ic_state_t                state;
  ic_state_t                next_state;
  logic [MEM_ADDR_BITS-1:0] fetch_addr;
  logic                     load_addr;

  // State register and latched block address; reset abandons any fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IC_IDLE;
      fetch_addr <= {MEM_ADDR_BITS{1'b0}};
    end else begin
      state <= next_state;
      if (load_addr) begin
        fetch_addr <= {req_tag, req_index};
      end else begin
        fetch_addr <= fetch_addr;
      end
    end
  end

  // Next-state and handshake decode; BUSYWAIT is forced low during reset.
  always_comb begin
    next_state = state;
    load_addr  = 1'b0;
    mem_read   = 1'b0;
    busywait   = 1'b0;
    capture    = 1'b0;
    line_write = 1'b0;
    case (state)
      IC_IDLE: begin
        busywait = !hit && !reset;
        if (!hit && !reset) begin
          next_state = IC_MEM_READ;
          load_addr  = 1'b1;
        end else begin
          next_state = IC_IDLE;
        end
      end
      IC_MEM_READ: begin
        mem_read = 1'b1;
        busywait = !reset;
        if (!mem_busywait) begin
          capture    = 1'b1;
          next_state = IC_UPDATE;
        end else begin
          next_state = IC_MEM_READ;
        end
      end
      IC_UPDATE: begin
        busywait   = !reset;
        line_write = !reset;
        next_state = IC_IDLE;
      end
      default: begin
        next_state = IC_IDLE;
      end
    endcase
  end

  assign mem_address = fetch_addr;

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache: 8 lines of 128-bit blocks over a
// 10-bit byte-address space. Hits return the word combinationally; misses
// stall the PC through BUSYWAIT while the controller fetches the block.
module icache_direct_mapped
  import cpu_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  output logic [WORD_BITS-1:0]  INSTRUCTION,
  output logic                  BUSYWAIT,
  icache_direct_mapped_if.master mem
);

  logic [BLOCK_BITS-1:0]  data_array [NUM_BLOCKS];
  logic [TAG_BITS-1:0]    tag_array  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0]  valid;
  logic [BLOCK_BITS-1:0]  fill_data;

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic                   hit;
  logic                   capture;
  logic                   line_write;
  logic [INDEX_BITS-1:0]  fill_index;
  logic [TAG_BITS-1:0]    fill_tag;

  // Upper PC bits alias onto the 1 KiB space by design.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

  assign offset = PC[3:2];
  assign index  = PC[6:4];
  assign tag    = PC[9:7];

  assign hit        = valid[index] && (tag_array[index] == tag);
  assign fill_index = mem.MEM_ADDRESS[INDEX_BITS-1:0];
  assign fill_tag   = mem.MEM_ADDRESS[MEM_ADDR_BITS-1:INDEX_BITS];

  icache_ctrl_fsm u_fsm (
    .clk          (CLK),
    .reset        (RESET),
    .hit          (hit),
    .req_tag      (tag),
    .req_index    (index),
    .mem_busywait (mem.MEM_BUSYWAIT),
    .mem_read     (mem.MEM_READ),
    .mem_address  (mem.MEM_ADDRESS),
    .busywait     (BUSYWAIT),
    .capture      (capture),
    .line_write   (line_write)
  );

  // Hold the returned block for one cycle before committing it to the line.
  always_ff @(posedge CLK) begin
    if (capture && !RESET) begin
      fill_data <= mem.MEM_READDATA;
    end else begin
      fill_data <= fill_data;
    end
  end

  // Valid bits: cleared on reset, set when a fill commits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= {NUM_BLOCKS{1'b0}};
    end else if (line_write) begin
      valid[fill_index] <= 1'b1;
    end else begin
      valid <= valid;
    end
  end

  // Data and tag arrays: a fill replaces the line unconditionally.
  always_ff @(posedge CLK) begin
    if (line_write && !RESET) begin
      data_array[fill_index] <= fill_data;
      tag_array[fill_index]  <= fill_tag;
    end
  end

  // Word select on hit; zero otherwise.
  always_comb begin
    INSTRUCTION = 32'h0000_0000;
    if (hit) begin
      INSTRUCTION = select_word(data_array[index], offset);
    end else begin
      INSTRUCTION = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped with a behavioural block memory
// whose busy time after MEM_READ rises is programmable.
module tb_icache_direct_mapped;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;

  icache_direct_mapped_if mem_if ();

  icache_direct_mapped dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .mem         (mem_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_cycles = 4;
  int rd_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Distinct recognisable word per block address and word offset.
  function automatic logic [31:0] mem_word(input logic [5:0] a, input logic [1:0] w);
    return {16'hC0DE, 2'b00, a, 6'b000000, w};
  endfunction

  // Memory model: count cycles MEM_READ has been high.
  always @(posedge CLK) begin
    if (mem_if.MEM_READ) rd_cnt <= rd_cnt + 1;
    else rd_cnt <= 0;
  end

  assign mem_if.MEM_BUSYWAIT = mem_if.MEM_READ && (rd_cnt < busy_cycles);
  assign mem_if.MEM_READDATA = {mem_word(mem_if.MEM_ADDRESS, 2'd3), mem_word(mem_if.MEM_ADDRESS, 2'd2),
                                mem_word(mem_if.MEM_ADDRESS, 2'd1), mem_word(mem_if.MEM_ADDRESS, 2'd0)};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Advance until BUSYWAIT falls; returns the number of edges taken.
  task automatic wait_fill(input int max, output int cyc);
    cyc = 0;
    while (BUSYWAIT === 1'b1 && cyc < max) begin
      step();
      cyc++;
    end
    if (BUSYWAIT !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL fill_timeout: got BUSYWAIT=%b after %0d cycles, expected 0", BUSYWAIT, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        exp_busy;
    logic        exp_read;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;

    vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, mem_word(6'd0, 2'd0)};
    vecs[1] = '{32'h0000_0004, 1'b0, 1'b0, mem_word(6'd0, 2'd1)};
    vecs[2] = '{32'h0000_0008, 1'b0, 1'b0, mem_word(6'd0, 2'd2)};
    vecs[3] = '{32'h0000_000C, 1'b0, 1'b0, mem_word(6'd0, 2'd3)};
    vecs[4] = '{32'h0000_0400, 1'b0, 1'b0, mem_word(6'd0, 2'd0)};
    vecs[5] = '{32'hFFFF_FC04, 1'b0, 1'b0, mem_word(6'd0, 2'd1)};

    // Reset held with the reset PC value: no stall, no request.
    RESET = 1'b1;
    PC    = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
      check("rst_mem_read", {31'd0, mem_if.MEM_READ}, 32'd0);
      check("rst_instr", INSTRUCTION, 32'd0);
    end
    check("rst_mem_addr", {26'd0, mem_if.MEM_ADDRESS}, 32'd0);

    // First miss at PC=0 with 4 busy cycles: 7-cycle penalty.
    RESET = 1'b0;
    PC    = 32'h0000_0000;
    #1;
    check("miss0_busy", {31'd0, BUSYWAIT}, 32'd1);
    check("miss0_read_c0", {31'd0, mem_if.MEM_READ}, 32'd0);
    step();
    check("miss0_read_c1", {31'd0, mem_if.MEM_READ}, 32'd1);
    check("miss0_addr", {26'd0, mem_if.MEM_ADDRESS}, 32'd0);
    wait_fill(50, cyc);
    check("miss0_penalty", cyc + 1, 32'd7);
    check("miss0_instr", INSTRUCTION, mem_word(6'd0, 2'd0));

    // Hit table: same-block words and aliased upper PC bits.
    for (int i = 0; i < 6; i++) begin
      PC = vecs[i].pc;
      #1;
      check($sformatf("hit%0d_busy", i), {31'd0, BUSYWAIT}, {31'd0, vecs[i].exp_busy});
      check($sformatf("hit%0d_read", i), {31'd0, mem_if.MEM_READ}, {31'd0, vecs[i].exp_read});
      check($sformatf("hit%0d_instr", i), INSTRUCTION, vecs[i].exp_instr);
      step();
    end

    // Conflict: tag 1 at index 0, then back to tag 0.
    PC = 32'h0000_0080;
    #1;
    check("conf1_busy", {31'd0, BUSYWAIT}, 32'd1);
    check("conf1_instr_miss", INSTRUCTION, 32'd0);
    step();
    check("conf1_addr", {26'd0, mem_if.MEM_ADDRESS}, 32'b001000);
    wait_fill(50, cyc);
    check("conf1_instr", INSTRUCTION, mem_word(6'b001000, 2'd0));
    PC = 32'h0000_0000;
    #1;
    check("conf0_busy", {31'd0, BUSYWAIT}, 32'd1);
    step();
    check("conf0_addr", {26'd0, mem_if.MEM_ADDRESS}, 32'd0);
    wait_fill(50, cyc);
    check("conf0_penalty", cyc + 1, 32'd7);
    check("conf0_instr", INSTRUCTION, mem_word(6'd0, 2'd0));

    // Reset two cycles into a miss abandons the request and clears valid.
    PC = 32'h0000_0010;
    #1;
    check("rmid_busy", {31'd0, BUSYWAIT}, 32'd1);
    step();
    check("rmid_read", {31'd0, mem_if.MEM_READ}, 32'd1);
    check("rmid_addr", {26'd0, mem_if.MEM_ADDRESS}, 32'd1);
    step();
    RESET = 1'b1;
    #1;
    check("rmid_busy_in_rst", {31'd0, BUSYWAIT}, 32'd0);
    step();
    check("rmid_read_after", {31'd0, mem_if.MEM_READ}, 32'd0);
    check("rmid_addr_after", {26'd0, mem_if.MEM_ADDRESS}, 32'd0);
    RESET = 1'b0;
    PC    = 32'h0000_0000;
    #1;
    check("rmid_refetch_busy", {31'd0, BUSYWAIT}, 32'd1);
    check("rmid_refetch_instr", INSTRUCTION, 32'd0);
    wait_fill(50, cyc);
    check("rmid_refetch_penalty", cyc, 32'd7);
    check("rmid_refetch_word", INSTRUCTION, mem_word(6'd0, 2'd0));

    // Zero-wait memory: miss completes in 3 cycles.
    busy_cycles = 0;
    PC = 32'h0000_0024;
    #1;
    check("fast_busy", {31'd0, BUSYWAIT}, 32'd1);
    step();
    check("fast_read", {31'd0, mem_if.MEM_READ}, 32'd1);
    check("fast_addr", {26'd0, mem_if.MEM_ADDRESS}, 32'd2);
    wait_fill(50, cyc);
    check("fast_penalty", cyc + 1, 32'd3);
    check("fast_instr", INSTRUCTION, mem_word(6'd2, 2'd1));

    // Reset again with PC=0xFFFFFFFC: everything quiet.
    RESET = 1'b1;
    PC    = 32'hFFFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst2_busywait", {31'd0, BUSYWAIT}, 32'd0);
      check("rst2_mem_read", {31'd0, mem_if.MEM_READ}, 32'd0);
      check("rst2_instr", INSTRUCTION, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache sitting directly downstream of the PC register.
- Consumes the 32-bit PC and returns INSTRUCTION to the decoder.
- Raises BUSYWAIT on a miss so the PC register holds its value. The PC register only advances when RESET=0 and BUSYWAIT=0, so PC is stable for the whole miss.
- On a miss, fetches one 128-bit block from instruction memory through a MEM_READ/MEM_BUSYWAIT handshake.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (power of two).
- INDEX_BITS, 3, log2(NUM_BLOCKS).
- TAG_BITS, 3, address bits above index; the byte-address space is 10 bits.
- BLOCK_BITS, 128, block width (4 x 32-bit words).

Ports:
- CLK  input  1  clock.
- RESET  input  1  reset.
- PC  input  32  fetch byte address; bits [9:0] used, [1:0] ignored.
- INSTRUCTION  output  32  fetched word.
- BUSYWAIT  output  1  high = stall PC.
- MEM_ADDRESS  output  6  block address {tag,index} to instruction memory.
- MEM_READ  output  1  block read request.
- MEM_READDATA  input  128  block data, word0 in [31:0].
- MEM_BUSYWAIT  input  1  memory busy.
- Reset RESET: synchronous, active-high. Clock CLK.

Behaviour:
- Address split:
  - offset = PC[3:2]
  - index = PC[6:4]
  - tag = PC[9:7]
- Storage: data[NUM_BLOCKS][128], tag[NUM_BLOCKS][3], valid[NUM_BLOCKS]. There is no dirty bit; the cache is read-only.
- hit = valid[index] && tag[index]==tag. It is combinational from PC and the arrays.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE: BUSYWAIT = !hit && !RESET. MEM_READ=0. On a miss, go to MEM_READ at the next edge.
  - MEM_READ: MEM_READ=1, MEM_ADDRESS={tag,index}, BUSYWAIT=1. Stay while MEM_BUSYWAIT=1. At the first edge with MEM_BUSYWAIT=0 and the request already issued, register MEM_READDATA and go to UPDATE.
  - UPDATE: MEM_READ=0, BUSYWAIT=1. At the next edge write data, tag and valid=1 for the index, then go to IDLE.
  - After returning to IDLE, the line now hits and BUSYWAIT falls combinationally in that same cycle.
- Hit latency: 0 cycles. INSTRUCTION is valid combinationally in the same cycle as PC.
- Miss penalty: 1 (IDLE->MEM_READ) + memory busy cycles + 1 (capture) + 1 (UPDATE) cycles.
- INSTRUCTION = selected word of data[index] when hit, else 32'h0.
- Reset (sampled at posedge):
  - all valid <= 0, state <= IDLE, MEM_READ <= 0, MEM_ADDRESS <= 0.
  - BUSYWAIT is 0 while RESET=1, which avoids stalling on the reset PC value 0xFFFFFFFC.
  - INSTRUCTION = 0 during and after reset until the first fill.
- Reset mid-fetch: abandon the request. MEM_READ drops at that edge and no array write occurs. Memory must tolerate a withdrawn request.
- Boundary cases:
  - PC bits [31:10] do not participate in tag compare; aliasing is accepted.
  - PC changing during a miss is a protocol violation. The FSM latches tag/index at the IDLE->MEM_READ edge and uses the latched values.
  - Two consecutive PCs in the same block: the second is a 0-cycle hit.
  - A conflict miss replaces the line unconditionally.
  - MEM_BUSYWAIT already low on the first MEM_READ cycle is legal. Capture occurs at the edge after MEM_READ is first asserted and MEM_BUSYWAIT is seen low.

Decomposition:
- Shared package cpu_pkg:
  - state encoding constants (IC_IDLE, IC_MEM_READ, IC_UPDATE)
  - field widths: OFFSET_BITS=2, INDEX_BITS, TAG_BITS, BLOCK_BITS
  - memory block address width (6)
- Sub-module: icache_ctrl_fsm. It holds the state register, latched tag/index and the handshake outputs. The arrays and hit logic stay in the top module.

Test Plan:
- Setup: memory model holds MEM_BUSYWAIT=1 for 4 cycles after MEM_READ rises, then returns the block.
- Reset then PC=0 -> BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=6'd0. BUSYWAIT falls 7 cycles after the miss starts. INSTRUCTION = memory word at 0.
- Sequential PC 0,4,8,12 after the fill -> each a 0-cycle hit, BUSYWAIT=0, words 0..3 returned, no MEM_READ.
- PC=0x80 (same index 0, tag 1) -> miss, MEM_ADDRESS=6'b001000. Then PC=0x000 -> miss again (conflict).
- RESET asserted 2 cycles into a miss -> MEM_READ=0 and state IDLE after the edge. A later PC=0 misses again because valid was cleared.
- RESET held with PC=0xFFFFFFFC -> BUSYWAIT=0, MEM_READ=0, INSTRUCTION=0 throughout.
- Memory with 0 busy cycles -> miss completes in 3 cycles and the correct word is returned.
